// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, constants and baud divisor helper
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   // Rounded clocks-per-oversample-tick, shared by the RX and TX sides
   function automatic int calc_divisor(input int sysclk, input int baud);
      return (sysclk + baud * (OVERSAMPLE / 2)) / (OVERSAMPLE * baud);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick generator, restartable so ticks align to a start edge
module uart_baud_tick #(
   parameter int DIVISOR = 4
) (
   input  logic SysClk,
   input  logic Reset_n,
   input  logic Clear,
   output logic Tick
);

   localparam int W = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

   logic [W-1:0] r_cnt;

   if (DIVISOR < 2) begin : g_div_check
      $error("uart_baud_tick: DIVISOR must be at least 2");
   end

   // Wrapping divider; Clear restarts it so the first tick lands DIVISOR cycles later
   always_ff @(posedge SysClk) begin
      if (!Reset_n || Clear) r_cnt <= '0;
      else                   r_cnt <= (r_cnt == W'(DIVISOR - 1)) ? '0 : r_cnt + 1'b1;
   end

   assign Tick = (r_cnt == W'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x oversampled UART receiver with even parity, stop checks and valid/ready output
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int SYSCLK_RATE = 1000000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 2
) (
   input  logic                 SysClk,
   input  logic                 Reset_n,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   input  logic                 RxReady,
   output logic                 ParityErr,
   output logic                 FramingErr,
   output logic                 Overrun,
   output logic                 Busy
);

   localparam int DIVISOR = calc_divisor(SYSCLK_RATE, BAUD_RATE);

   rx_state_t            r_state;
   logic [1:0]           r_sync;
   logic                 r_rx_prev;
   logic [3:0]           r_scount;
   logic [3:0]           r_bitcnt;
   logic                 r_stopcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic                 r_ferr;

   logic w_rx_s;
   logic w_fall;
   logic w_tick;
   logic w_mid;
   logic w_end;
   logic w_ferr_next;
   logic w_done;

   // Two-flop synchronizer plus previous-sample register for falling-edge detection
   always_ff @(posedge SysClk) begin
      if (!Reset_n) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync    <= {r_sync[0], RxD};
         r_rx_prev <= w_rx_s;
      end
   end

   assign w_rx_s = r_sync[1];

   uart_baud_tick #(
      .DIVISOR(DIVISOR)
   ) u_tick (
      .SysClk (SysClk),
      .Reset_n(Reset_n),
      .Clear  (w_fall),
      .Tick   (w_tick)
   );

   // Sampling strobes and frame-completion condition
   always_comb begin
      w_fall      = (r_state == IDLE) && r_rx_prev && !w_rx_s;
      w_mid       = w_tick && (r_scount == 4'(MID_SAMPLE));
      w_end       = w_tick && (r_scount == 4'(OVERSAMPLE - 1));
      w_ferr_next = r_ferr | ~w_rx_s;
      w_done      = (r_state == STOP) && w_mid && (r_stopcnt == 1'(STOP_BITS - 1));
   end

   // Frame FSM with registered word delivery and overrun reporting
   always_ff @(posedge SysClk) begin
      if (!Reset_n) begin
         r_state    <= IDLE;
         r_scount   <= '0;
         r_bitcnt   <= '0;
         r_stopcnt  <= 1'b0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         RxData     <= '0;
         RxValid    <= 1'b0;
         ParityErr  <= 1'b0;
         FramingErr <= 1'b0;
         Overrun    <= 1'b0;
      end else begin
         Overrun <= 1'b0;
         if (r_state != IDLE && w_tick) r_scount <= r_scount + 4'd1;
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state   <= START;
                  r_scount  <= '0;
                  r_bitcnt  <= '0;
                  r_stopcnt <= 1'b0;
                  r_ferr    <= 1'b0;
               end
            end
            START: begin
               if (w_mid && w_rx_s) r_state <= IDLE;
               else if (w_end)      r_state <= DATA;
            end
            DATA: begin
               if (w_mid) begin
                  r_shift  <= DATA_BITS'({w_rx_s, r_shift} >> 1);
                  r_bitcnt <= r_bitcnt + 4'd1;
               end
               if (w_end && r_bitcnt == 4'(DATA_BITS)) r_state <= PARITY;
            end
            PARITY: begin
               if (w_mid) r_perr <= w_rx_s ^ (^r_shift);
               if (w_end) r_state <= STOP;
            end
            STOP: begin
               if (w_mid) begin
                  r_ferr <= w_ferr_next;
                  if (w_done) r_state <= IDLE;
                  else        r_stopcnt <= r_stopcnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_done) begin
            if (!RxValid || RxReady) begin
               RxData     <= r_shift;
               ParityErr  <= r_perr;
               FramingErr <= w_ferr_next;
               RxValid    <= 1'b1;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (RxValid && RxReady) begin
            RxValid <= 1'b0;
         end
      end
   end

   assign Busy = (r_state != IDLE);

endmodule
